// File: rtl/matrix_engine_if.sv
// rtl/matrix_engine_if.sv - command, RAM and status bundle for matrix_engine
// Purpose: groups the command handshake, the RAM port and the status flags.
// Signals:
//   start, op, size, scalar        - command, driven by the master
//   mem_addr, mem_wdata, mem_wren  - RAM request, driven by the engine
//   mem_rdata                      - RAM read data, driven by the master side
//   busy, done, overflow, error    - status, driven by the engine
// Modports: master (command issuer / RAM owner), slave (the engine).
interface matrix_engine_if #(
    parameter int ELEM_W = 8,
    parameter int WORD_W = 256,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [2:0]        op;
    logic [2:0]        size;
    logic [ELEM_W-1:0] scalar;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_wren;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              error;

    modport master (
        output start, op, size, scalar, mem_rdata,
        input  mem_addr, mem_wdata, mem_wren, busy, done, overflow, error
    );

    modport slave (
        input  start, op, size, scalar, mem_rdata,
        output mem_addr, mem_wdata, mem_wren, busy, done, overflow, error
    );
endinterface

// File: rtl/matrix_engine.sv
// rtl/matrix_engine.sv - sequential N x N signed saturating matrix coprocessor
// Purpose: reads A and B from a word-wide RAM, computes add, sub, multiply,
// transpose or scalar multiply for a runtime size N, writes the packed result.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - matrix_engine_if.slave: start/op/size/scalar command,
//           mem_addr/mem_rdata/mem_wdata/mem_wren RAM port,
//           busy/done/overflow/error status
module matrix_engine #(
    parameter int ELEM_W = 8,
    parameter int MAX_N  = 5,
    parameter int WORD_W = 256,
    parameter int ADDR_W = 8,
    parameter int BASE_A = 0,
    parameter int BASE_B = 1,
    parameter int BASE_R = 2
) (
    input  logic           clock,
    input  logic           reset,
    matrix_engine_if.slave bus
);
    localparam int ACC_W = 2 * ELEM_W + 3;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (ELEM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [WORD_W-1:0] TOP_MASK = {{ELEM_W{1'b1}}, {(WORD_W-ELEM_W){1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_A = ADDR_W'(BASE_A);
    localparam logic [ADDR_W-1:0] ADDR_B = ADDR_W'(BASE_B);
    localparam logic [ADDR_W-1:0] ADDR_R = ADDR_W'(BASE_R);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_TRN   = 3'd3;
    localparam logic [2:0] OP_SCALE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_LAT_B, S_COMPUTE, S_WRITE, S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_n;
    logic [2:0]               r_op;
    logic [2:0]               r_n;
    logic [2:0]               r_i;
    logic [2:0]               r_j;
    logic [2:0]               r_k;
    logic signed [ELEM_W-1:0] r_scalar;
    logic [WORD_W-1:0]        r_a;
    logic [WORD_W-1:0]        r_b;
    logic [WORD_W-1:0]        r_res;
    logic signed [ACC_W-1:0]  r_acc;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [WORD_W-1:0]        r_mem_wdata;
    logic                     r_mem_wren;
    logic                     r_ovf;
    logic                     r_err;

    logic                     w_legal;
    logic                     w_mul;
    logic                     w_last_i;
    logic                     w_last_j;
    logic                     w_last_k;
    logic                     w_emit;
    logic                     w_last;
    int                       w_idx_ij;
    int                       w_idx_ji;
    int                       w_idx_ik;
    int                       w_idx_kj;
    logic signed [ACC_W-1:0]  w_val;
    logic signed [ACC_W-1:0]  w_acc_n;
    logic signed [ELEM_W-1:0] w_elem;
    logic                     w_sat;
    logic [WORD_W-1:0]        w_res_n;

    // Element idx of the dense row-major packing sits at the top after shifting left.
    function automatic logic signed [ELEM_W-1:0] get_elem(input logic [WORD_W-1:0] word,
                                                           input int idx);
        logic [WORD_W-1:0] shifted;
        shifted = word << (idx * ELEM_W);
        return shifted[WORD_W-1 -: ELEM_W];
    endfunction

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [ELEM_W-1:0] v);
        return {{(ACC_W-ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    assign w_legal  = (bus.op <= OP_SCALE) && (bus.size >= 3'd2) && (int'(bus.size) <= MAX_N);
    assign w_mul    = (r_op == OP_MUL);
    assign w_last_i = (r_i == r_n - 3'd1);
    assign w_last_j = (r_j == r_n - 3'd1);
    assign w_last_k = (r_k == r_n - 3'd1);
    // Multiply emits one element per full k sweep; other ops emit every cycle.
    assign w_emit   = !w_mul || w_last_k;
    assign w_last   = w_emit && w_last_j && w_last_i;

    always_comb begin
        w_idx_ij = int'(r_i) * int'(r_n) + int'(r_j);
        w_idx_ji = int'(r_j) * int'(r_n) + int'(r_i);
        w_idx_ik = int'(r_i) * int'(r_n) + int'(r_k);
        w_idx_kj = int'(r_k) * int'(r_n) + int'(r_j);
        w_acc_n  = r_acc;
        w_val    = '0;
        case (r_op)
            OP_ADD:   w_val = ext(get_elem(r_a, w_idx_ij)) + ext(get_elem(r_b, w_idx_ij));
            OP_SUB:   w_val = ext(get_elem(r_a, w_idx_ij)) - ext(get_elem(r_b, w_idx_ij));
            OP_MUL: begin
                w_acc_n = ((r_k == 3'd0) ? '0 : r_acc)
                        + ext(get_elem(r_a, w_idx_ik)) * ext(get_elem(r_b, w_idx_kj));
                w_val   = w_acc_n;
            end
            OP_TRN:   w_val = ext(get_elem(r_a, w_idx_ji));
            OP_SCALE: w_val = ext(get_elem(r_a, w_idx_ij)) * ext(r_scalar);
            default:  w_val = '0;
        endcase

        w_sat  = 1'b0;
        w_elem = w_val[ELEM_W-1:0];
        if (w_val > SAT_MAX) begin
            w_elem = SAT_MAX[ELEM_W-1:0];
            w_sat  = 1'b1;
        end else if (w_val < SAT_MIN) begin
            w_elem = SAT_MIN[ELEM_W-1:0];
            w_sat  = 1'b1;
        end

        // Result word with element (i,j) replaced; also feeds mem_wdata on the last cycle.
        w_res_n = (r_res & ~(TOP_MASK >> (w_idx_ij * ELEM_W)))
                | ({w_elem, {(WORD_W-ELEM_W){1'b0}}} >> (w_idx_ij * ELEM_W));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_n = w_legal ? S_RD_A : S_DONE;
            S_RD_A:    w_state_n = S_RD_B;
            S_RD_B:    w_state_n = S_LAT_B;
            S_LAT_B:   w_state_n = S_COMPUTE;
            S_COMPUTE: if (w_last) w_state_n = S_WRITE;
            S_WRITE:   w_state_n = S_DONE;
            S_DONE:    w_state_n = S_IDLE;
            default:   w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op        <= '0;
            r_n         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_scalar    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_acc       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_n      <= bus.size;
                        r_scalar <= bus.scalar;
                        r_ovf    <= 1'b0;
                        r_err    <= !w_legal;
                        r_res    <= '0;
                        r_acc    <= '0;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        if (w_legal) r_mem_addr <= ADDR_A;
                    end
                end
                S_RD_A:  r_mem_addr <= ADDR_B;
                S_RD_B:  r_a <= bus.mem_rdata;
                S_LAT_B: r_b <= bus.mem_rdata;
                S_COMPUTE: begin
                    r_acc <= w_acc_n;
                    if (w_emit) begin
                        r_res <= w_res_n;
                        if (w_sat) r_ovf <= 1'b1;
                    end
                    if (w_mul && !w_last_k) begin
                        r_k <= r_k + 3'd1;
                    end else begin
                        r_k <= '0;
                        if (!w_last_j) begin
                            r_j <= r_j + 3'd1;
                        end else begin
                            r_j <= '0;
                            r_i <= r_i + 3'd1;
                        end
                    end
                    if (w_last) begin
                        r_mem_addr  <= ADDR_R;
                        r_mem_wdata <= w_res_n;
                        r_mem_wren  <= 1'b1;
                    end
                end
                S_WRITE: r_mem_wren <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wren  = r_mem_wren;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.overflow  = r_ovf;
    assign bus.error     = r_err;
endmodule

// File: tb/tb_matrix_engine.sv
// tb/tb_matrix_engine.sv - scoreboard bench for matrix_engine
module tb_matrix_engine;
    localparam int WORD_W = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    matrix_engine_if bus();

    matrix_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [WORD_W-1:0] word;
        logic              ovf;
        logic              err;
        int                lat;
        int                wrens;
    } exp_t;

    exp_t              sb[$];
    int                n_checks = 0;
    int                n_fails  = 0;
    int                cyc      = 0;
    int                acc_cyc  = 0;
    int                wren_cnt = 0;
    logic [WORD_W-1:0] ram [0:3];
    logic              ld_en    = 1'b0;
    logic [1:0]        ld_addr  = '0;
    logic [WORD_W-1:0] ld_data  = '0;
    logic [WORD_W-1:0] last_word = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        bus.mem_rdata <= ram[bus.mem_addr[1:0]];
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (bus.mem_wren) ram[bus.mem_addr[1:0]] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] pack(input int v[$]);
        logic [WORD_W-1:0] w;
        w = '0;
        foreach (v[k]) w[WORD_W-1-k*8 -: 8] = v[k][7:0];
        return w;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (bus.mem_wren) begin
                wren_cnt++;
                chk("wr_addr", bus.mem_addr, 2);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("error", bus.error, e.err);
                    chk("overflow", bus.overflow, e.ovf);
                    chk("latency", cyc - acc_cyc + 1, e.lat);
                    chk("wren_count", wren_cnt, e.wrens);
                    chk("result", ram[2], e.word);
                    wren_cnt = 0;
                end
            end
        end
    end

    task automatic load(input logic [1:0] a, input logic [WORD_W-1:0] d);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] sc);
        @(negedge clock);
        bus.op = op; bus.size = sz; bus.scalar = sc; bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!bus.done && t < 400);
        if (!bus.done) chk("done_timeout", bus.done, 1);
        @(negedge clock);
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] sc,
                       input logic [WORD_W-1:0] word, input logic ovf, input logic err,
                       input int lat);
        exp_t e;
        e.ovf = ovf; e.err = err; e.lat = lat; e.wrens = err ? 0 : 1;
        if (!err) last_word = word;
        e.word = last_word;
        sb.push_back(e);
        issue(op, sz, sc);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   q[$];
        logic busy_seen;
        bus.start = 1'b0; bus.op = '0; bus.size = '0; bus.scalar = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", bus.busy, 0);

        load(2, '1);
        last_word = '1;

        // add N=2
        q = '{1, 2, 3, 4};   load(0, pack(q));
        q = '{5, 6, 7, 8};   load(1, pack(q));
        q = '{6, 8, 10, 12}; run(3'd0, 3'd2, 8'd0, pack(q), 1'b0, 1'b0, 9);

        // sub N=4 with negative saturation
        q.delete(); for (int k = 0; k < 16; k++) q.push_back(10 * (k + 1)); load(0, pack(q));
        q.delete(); for (int k = 0; k < 16; k++) q.push_back(k + 1);        load(1, pack(q));
        q = '{9, 18, 27, 36, 45, 54, 63, 72, 81, 90, 99, 108, -128, -128, -121, -112};
        run(3'd1, 3'd4, 8'd0, pack(q), 1'b1, 1'b0, 21);

        // multiply N=2, no saturation
        q = '{10, 20, -3, 4};    load(0, pack(q));
        q = '{7, -1, 2, 5};      load(1, pack(q));
        q = '{110, 90, -13, 23}; run(3'd2, 3'd2, 8'd0, pack(q), 1'b0, 1'b0, 13);

        // multiply N=2, saturating both ways
        q = '{100, -100, 50, 1};  load(0, pack(q));
        q = '{2, 0, 0, 3};        load(1, pack(q));
        q = '{127, -128, 100, 3}; run(3'd2, 3'd2, 8'd0, pack(q), 1'b1, 1'b0, 13);

        // multiply N=5, identity times ones
        q.delete(); for (int k = 0; k < 25; k++) q.push_back((k % 6 == 0) ? 1 : 0); load(0, pack(q));
        q.delete(); for (int k = 0; k < 25; k++) q.push_back(1);                     load(1, pack(q));
        run(3'd2, 3'd5, 8'd0, pack(q), 1'b0, 1'b0, 130);

        // scalar and transpose N=3
        q = '{100, 1, 2, 3, 4, 5, 6, 7, 8}; load(0, pack(q));
        q = '{127, 2, 4, 6, 8, 10, 12, 14, 16};
        run(3'd4, 3'd3, 8'd2, pack(q), 1'b1, 1'b0, 14);
        q = '{100, 3, 6, 1, 4, 7, 2, 5, 8};
        run(3'd3, 3'd3, 8'd0, pack(q), 1'b0, 1'b0, 14);

        // illegal commands
        run(3'd0, 3'd6, 8'd0, '0, 1'b0, 1'b1, 1);
        run(3'd7, 3'd3, 8'd0, '0, 1'b0, 1'b1, 1);
        run(3'd2, 3'd1, 8'd0, '0, 1'b0, 1'b1, 1);
        repeat (2) @(negedge clock);
        chk("error_held", bus.error, 1);

        // reset in cycle 50 of a multiply, with an ignored start while busy
        q.delete(); for (int k = 0; k < 25; k++) q.push_back((k % 6 == 0) ? 1 : 0); load(0, pack(q));
        issue(3'd2, 3'd5, 8'd0);
        repeat (9) @(negedge clock);
        bus.op = 3'd0; bus.size = 3'd2; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        chk("busy_mid_mul", bus.busy, 1);
        repeat (40) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        chk("mid_rst_error", bus.error, 0);
        chk("mid_rst_wren", bus.mem_wren, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        chk("mid_rst_wdata", bus.mem_wdata, 0);
        @(negedge clock);
        reset = 1'b0;
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge clock);
            busy_seen = busy_seen | bus.busy;
        end
        chk("restart_ignored", busy_seen, 0);
        chk("reset_no_write", wren_cnt, 0);
        chk("ram_kept", ram[2], last_word);

        // recovery after reset
        q = '{1, 2, 3, 4};   load(0, pack(q));
        q = '{5, 6, 7, 8};   load(1, pack(q));
        q = '{6, 8, 10, 12}; run(3'd0, 3'd2, 8'd0, pack(q), 1'b0, 1'b0, 9);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
